// File: rtl/ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_ctrl_if
// Host-side handshake bundle for ram_ctrl.
//
// Signals
//   req    host -> ctrl  access request, only looked at while the controller is idle
//   we     host -> ctrl  1 = write, 0 = read
//   inc    host -> ctrl  1 = address from the internal pointer, 0 = use addr
//   addr   host -> ctrl  explicit access address
//   wdata  host -> ctrl  write nibble
//   busy   ctrl -> host  controller is in the middle of an access
//   ack    ctrl -> host  one-cycle completion pulse
//   rdata  ctrl -> host  most recently read nibble
//   ptr    ctrl -> host  auto-increment pointer
//
// Modports
//   master  the requesting side (testbench / host logic)
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface ram_ctrl_if;

    logic       req;
    logic       we;
    logic       inc;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic       busy;
    logic       ack;
    logic [3:0] rdata;
    logic [7:0] ptr;

    modport master (
        output req,
        output we,
        output inc,
        output addr,
        output wdata,
        input  busy,
        input  ack,
        input  rdata,
        input  ptr
    );

    modport slave (
        input  req,
        input  we,
        input  inc,
        input  addr,
        input  wdata,
        output busy,
        output ack,
        output rdata,
        output ptr
    );

endinterface

// File: rtl/ram_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ctrl
// Sequences single-nibble reads and writes to an asynchronous 256x4 RAM that
// shares one bidirectional data bus with this controller. Every access takes
// three busy cycles (SETUP, WSTROBE or RSAMPLE, DONE) followed by at least one
// IDLE cycle. The address can come from the host or from an internal pointer
// that always ends up one past the last address that was accessed.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   host      ram_ctrl_if.slave: req/we/inc/addr/wdata in, busy/ack/rdata/ptr out
//   ram_addr  RAM address bus, held stable through a whole access
//   ram_data  RAM data bus; driven here only while strobing a write
//   ram_we_n  RAM write enable, active low; the RAM drives the bus while high
// ---------------------------------------------------------------------------
module ram_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    ram_ctrl_if.slave    host,
    output logic [7:0]   ram_addr,
    inout  wire  [3:0]   ram_data,
    output logic         ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        RSAMPLE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       lat_we;
    logic [3:0] lat_wdata;
    logic [7:0] addr_q;
    logic [7:0] ptr_q;
    logic [3:0] rdata_q;

    logic       accept;
    logic [7:0] eff_addr;
    logic       drive_bus;

    // A request only counts while idle; anything arriving during an access is
    // simply not looked at, so there is no queueing.
    assign accept   = (state == IDLE) && host.req;
    assign eff_addr = host.inc ? ptr_q : host.addr;

    // State register. Reset drops straight back to IDLE, which aborts any
    // access in flight without an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The read/write split is taken from the command latched
    // at acceptance, not from the live we input, which may already have moved.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host.req) state_next = SETUP;
            SETUP:   state_next = lat_we ? WSTROBE : RSAMPLE;
            WSTROBE: state_next = DONE;
            RSAMPLE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. Everything the RAM sees is a pure function of the state
    // register, so reset releases the bus and raises ram_we_n the moment it is
    // asserted instead of waiting for a clock edge.
    always_comb begin
        host.busy = 1'b1;
        host.ack  = 1'b0;
        ram_we_n  = 1'b1;
        drive_bus = 1'b0;
        case (state)
            IDLE:    host.busy = 1'b0;
            WSTROBE: begin
                ram_we_n  = 1'b0;
                drive_bus = 1'b1;
            end
            DONE:    host.ack = 1'b1;
            default: ;
        endcase
    end

    assign ram_data = drive_bus ? lat_wdata : 4'bz;

    // Command capture at the acceptance edge. The address register doubles as
    // the RAM address bus, so it keeps its value while idle and only changes
    // when the next access is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_we    <= 1'b0;
            lat_wdata <= 4'h0;
            addr_q    <= 8'h00;
        end else if (accept) begin
            lat_we    <= host.we;
            lat_wdata <= host.wdata;
            addr_q    <= eff_addr;
        end
    end

    // Read data is sampled off the shared bus on the edge leaving RSAMPLE;
    // the RAM has had the address for a full SETUP cycle by then. Writes never
    // pass through here, so rdata holds the last read across them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 4'h0;
        end else if (state == RSAMPLE) begin
            rdata_q <= ram_data;
        end
    end

    // Pointer update on the edge entering DONE, for every access. An explicit
    // access therefore seeds the pointer, and 8'hFF rolls over to 8'h00 through
    // the natural 8-bit wrap of the adder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 8'h00;
        end else if ((state == WSTROBE) || (state == RSAMPLE)) begin
            ptr_q <= addr_q + 8'd1;
        end
    end

    assign ram_addr   = addr_q;
    assign host.rdata = rdata_q;
    assign host.ptr   = ptr_q;

endmodule
